// File: rtl/fetch_pc_redirect.sv
// IF-stage PC owner: sequential fetch, decode jump redirect applied after the
// delay slot is issued, and memory-stage exception redirect override.
module fetch_pc_redirect #(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallF,
    input  logic              jumpD,
    input  logic [ADDR_W-1:0] pc_jumpD,
    input  logic [ADDR_W-1:0] PcPlus4D,
    input  logic              ex_redirectM,
    input  logic [ADDR_W-1:0] ex_pcM,
    output logic              inst_req,
    input  logic              inst_addr_ok,
    output logic [ADDR_W-1:0] pcF,
    output logic              redirect_pending
);

    typedef enum logic {
        IDLE    = 1'b0,
        WAIT_DS = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] last_iss_q, last_iss_d;
    logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
    logic [ADDR_W-1:0] pend_ds_q, pend_ds_d;

    logic              ds_already_issued;
    logic              kill_seq;
    logic              issue;
    logic [ADDR_W-1:0] seq_pc;

    // A jump whose delay slot already went out makes the sequential fetch wrong-path.
    assign ds_already_issued = (last_iss_q == PcPlus4D);
    assign kill_seq          = jumpD & ds_already_issued & (state_q == IDLE);
    assign inst_req          = ~rst & ~stallF & ~ex_redirectM & ~kill_seq;
    assign issue             = inst_req & inst_addr_ok;
    assign seq_pc            = issue ? (pc_q + ADDR_W'(4)) : pc_q;

    assign pcF              = pc_q;
    assign redirect_pending = (state_q == WAIT_DS) & ~rst;

    always_comb begin
        state_d    = state_q;
        pc_d       = seq_pc;
        last_iss_d = last_iss_q;
        pend_tgt_d = pend_tgt_q;
        pend_ds_d  = pend_ds_q;

        if (issue) begin
            last_iss_d = pc_q;
        end

        if (ex_redirectM) begin
            pc_d    = ex_pcM;
            state_d = IDLE;
        end else if ((state_q == IDLE) && jumpD) begin
            if (ds_already_issued || ((pc_q == PcPlus4D) && issue)) begin
                pc_d = pc_jumpD;
            end else begin
                pend_tgt_d = pc_jumpD;
                pend_ds_d  = PcPlus4D;
                state_d    = WAIT_DS;
            end
        end else if ((state_q == WAIT_DS) && issue && (pc_q == pend_ds_q)) begin
            pc_d    = pend_tgt_q;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            last_iss_q <= RESET_PC - ADDR_W'(4);
            pend_tgt_q <= '0;
            pend_ds_q  <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            last_iss_q <= last_iss_d;
            pend_tgt_q <= pend_tgt_d;
            pend_ds_q  <= pend_ds_d;
        end
    end

    // Decode must hold its jump until the delay slot can be located and must stall while one is pending.
    a_jump_ds_known: assert property (@(posedge clk) disable iff (rst)
        (jumpD && (state_q == IDLE)) |-> (ds_already_issued || (pc_q == PcPlus4D)));

    a_no_jump_while_pending: assert property (@(posedge clk) disable iff (rst)
        (state_q == WAIT_DS) |-> !jumpD);

endmodule

// File: tb/tb_fetch_pc_redirect.sv
// Self-checking bench for fetch_pc_redirect: directed scenarios followed by
// protocol-legal random stimulus compared against a behavioural fetch model.
module tb_fetch_pc_redirect;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;

    logic        clk;
    logic        rst;
    logic        stallF;
    logic        jumpD;
    logic [31:0] pc_jumpD;
    logic [31:0] PcPlus4D;
    logic        ex_redirectM;
    logic [31:0] ex_pcM;
    logic        inst_req;
    logic        inst_addr_ok;
    logic [31:0] pcF;
    logic        redirect_pending;

    int errors;
    int checks;

    // Behavioural model of the fetch unit
    logic [31:0] m_pc;
    logic [31:0] m_last;
    logic        m_pend;
    logic [31:0] m_ptgt;
    logic [31:0] m_pds;
    logic        have_reset;

    fetch_pc_redirect #(
        .ADDR_W  (32),
        .RESET_PC(RST_PC)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stallF          (stallF),
        .jumpD           (jumpD),
        .pc_jumpD        (pc_jumpD),
        .PcPlus4D        (PcPlus4D),
        .ex_redirectM    (ex_redirectM),
        .ex_pcM          (ex_pcM),
        .inst_req        (inst_req),
        .inst_addr_ok    (inst_addr_ok),
        .pcF             (pcF),
        .redirect_pending(redirect_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, check outputs mid-cycle, then advance the model across the edge.
    task automatic applyStimulus(input logic r, input logic st, input logic j,
                                 input logic [31:0] tgt, input logic [31:0] ds,
                                 input logic ex, input logic [31:0] expc, input logic ok);
        logic        exp_req;
        logic        fire;
        logic [31:0] nxt;
        rst          = r;
        stallF       = st;
        jumpD        = j;
        pc_jumpD     = tgt;
        PcPlus4D     = ds;
        ex_redirectM = ex;
        ex_pcM       = expc;
        inst_addr_ok = ok;
        #2;
        exp_req = !r && !st && !ex && !(j && !m_pend && (m_last == ds));
        checkOutput("inst_req", {31'd0, inst_req}, {31'd0, exp_req});
        if (have_reset) begin
            checkOutput("redirect_pending", {31'd0, redirect_pending}, {31'd0, (!r && m_pend)});
            if (!r) checkOutput("pcF", pcF, m_pc);
        end
        @(posedge clk);
        if (r) begin
            m_pc       = RST_PC;
            m_last     = RST_PC - 32'd4;
            m_pend     = 1'b0;
            m_ptgt     = '0;
            m_pds      = '0;
            have_reset = 1'b1;
        end else if (ex) begin
            m_pc   = expc;
            m_pend = 1'b0;
        end else begin
            fire = exp_req && ok;
            nxt  = fire ? m_pc + 32'd4 : m_pc;
            if (j && !m_pend) begin
                if ((m_last == ds) || ((m_pc == ds) && fire)) begin
                    nxt = tgt;
                end else begin
                    m_pend = 1'b1;
                    m_ptgt = tgt;
                    m_pds  = ds;
                end
            end else if (m_pend && fire && (m_pc == m_pds)) begin
                nxt    = m_ptgt;
                m_pend = 1'b0;
            end
            if (fire) m_last = m_pc;
            m_pc = nxt;
        end
        #1;
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b1);
    endtask

    task automatic idle(input logic ok);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, ok);
    endtask

    initial begin
        logic        r_rst, r_st, r_j, r_ex, r_ok;
        logic [31:0] r_tgt, r_ds, r_expc;
        errors     = 0;
        checks     = 0;
        have_reset = 1'b0;
        m_pc       = '0;
        m_last     = '0;
        m_pend     = 1'b0;
        m_ptgt     = '0;
        m_pds      = '0;

        // Reset and free-running sequential fetch
        doReset();
        checkOutput("t1_pc0", pcF, 32'hBFC0_0000);
        checkOutput("t1_pend0", {31'd0, redirect_pending}, 32'd0);
        idle(1'b1);
        checkOutput("t1_pc1", pcF, 32'hBFC0_0004);
        idle(1'b1);
        checkOutput("t1_pc2", pcF, 32'hBFC0_0008);
        idle(1'b1);

        // Delay slot already issued: sequential fetch killed, target next cycle
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h8000_1000, 32'hBFC0_0008, 1'b0, 32'd0, 1'b1);
        checkOutput("t2_pc_target", pcF, 32'h8000_1000);
        idle(1'b1);
        checkOutput("t2_pc_after", pcF, 32'h8000_1004);

        // Delay slot pending behind a busy SRAM
        doReset();
        idle(1'b1);
        idle(1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h8000_2000, 32'hBFC0_0008, 1'b0, 32'd0, 1'b0);
        checkOutput("t3_pend", {31'd0, redirect_pending}, 32'd1);
        checkOutput("t3_pc_hold", pcF, 32'hBFC0_0008);
        idle(1'b0);
        idle(1'b0);
        idle(1'b1);
        checkOutput("t3_pc_target", pcF, 32'h8000_2000);
        checkOutput("t3_pend_clr", {31'd0, redirect_pending}, 32'd0);

        // Pending jump held across a fetch stall
        doReset();
        idle(1'b1);
        idle(1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h8000_3000, 32'hBFC0_0008, 1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b1);
        checkOutput("t4_pc_hold", pcF, 32'hBFC0_0008);
        idle(1'b1);
        checkOutput("t4_pc_target", pcF, 32'h8000_3000);

        // Exception overrides a same-cycle jump and a pending one
        doReset();
        idle(1'b1);
        idle(1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h8000_4000, 32'hBFC0_0008, 1'b1, 32'hBFC0_0380, 1'b1);
        checkOutput("t5_pc_exc", pcF, 32'hBFC0_0380);
        checkOutput("t5_pend", {31'd0, redirect_pending}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h8000_5000, 32'hBFC0_0380, 1'b0, 32'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'hBFC0_0380, 1'b1);
        checkOutput("t5_pc_exc2", pcF, 32'hBFC0_0380);
        checkOutput("t5_pend2", {31'd0, redirect_pending}, 32'd0);
        idle(1'b1);
        checkOutput("t5_pc_seq", pcF, 32'hBFC0_0384);

        // Reset while a jump is pending
        doReset();
        idle(1'b1);
        idle(1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h8000_6000, 32'hBFC0_0008, 1'b0, 32'd0, 1'b0);
        doReset();
        checkOutput("t6_pc_reset", pcF, 32'hBFC0_0000);
        checkOutput("t6_pend", {31'd0, redirect_pending}, 32'd0);
        idle(1'b1);
        checkOutput("t6_pc_seq", pcF, 32'hBFC0_0004);

        // Random protocol-legal traffic
        for (int n = 0; n < 2000; n++) begin
            r_rst  = ($urandom_range(0, 63) == 0);
            r_ex   = ($urandom_range(0, 31) == 0);
            r_st   = ($urandom_range(0, 3) == 0);
            r_ok   = ($urandom_range(0, 3) != 0);
            r_tgt  = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            r_expc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            r_ds   = $urandom();
            r_j    = 1'b0;
            if (!m_pend && ($urandom_range(0, 4) == 0)) begin
                r_j  = 1'b1;
                r_ds = $urandom_range(0, 1) ? m_last : m_pc;
            end
            applyStimulus(r_rst, r_st, r_j, r_tgt, r_ds, r_ex, r_expc, r_ok);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_pc_redirect.md
Name: fetch_pc_redirect

Overview:
- Fetch-side consumer of the decode-stage jump redirect (jump taken flag plus target). Owns the IF-stage PC register and drives the instruction-SRAM request address.
- Applies a decode jump only after the branch delay slot (PcPlus4D) has been issued to the instruction SRAM. If the delay slot has not yet been issued, the target is held in a pending buffer until it is.
- An exception redirect from the memory stage overrides everything.

Parameters:
- RESET_PC, 32'hBFC0_0000, first fetch address after reset.
- ADDR_W, 32, PC/address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- stallF  in  1  fetch stall; no request issued while high.
- jumpD  in  1  decode-stage jump taken; valid for one cycle per jump instruction.
- pc_jumpD  in  ADDR_W  decode-stage jump target.
- PcPlus4D  in  ADDR_W  PC+4 of the jump in decode, i.e. the delay-slot address.
- ex_redirectM  in  1  exception/eret redirect pulse.
- ex_pcM  in  ADDR_W  exception/eret target.
- inst_req  out  1  instruction-SRAM request valid.
- inst_addr_ok  in  1  SRAM accepts the request this cycle.
- pcF  out  ADDR_W  current fetch address; also drives the request address.
- redirect_pending  out  1  a jump target is buffered, waiting for its delay slot.

Behaviour:
- Reset (rst=1 at a clk edge):
  - pcF=RESET_PC, last_iss=RESET_PC-4, state=IDLE, pend_tgt=0.
  - inst_req=0 and redirect_pending=0 while rst is high.
- issue = inst_req & inst_addr_ok. On issue, last_iss<=pcF.
- inst_req = ~rst & ~stallF & ~ex_redirectM & ~kill_seq.
  - kill_seq = jumpD & (last_iss==PcPlus4D) & state==IDLE. This suppresses the wrong-path sequential fetch.
- States: IDLE, WAIT_DS. redirect_pending = (state==WAIT_DS).
- Next-pcF priority, highest first:
  1. ex_redirectM: pcF<=ex_pcM; state<=IDLE; pending dropped. Any jumpD in the same cycle is ignored.
  2. IDLE & jumpD & last_iss==PcPlus4D (delay slot already issued): pcF<=pc_jumpD. No request this cycle.
  3. IDLE & jumpD & pcF==PcPlus4D & issue (delay slot issued this cycle): pcF<=pc_jumpD.
  4. IDLE & jumpD & delay slot not issued: pend_tgt<=pc_jumpD; state<=WAIT_DS; pcF holds or advances per rule 6.
  5. WAIT_DS & issue & pcF==PcPlus4D_latched: pcF<=pend_tgt; state<=IDLE.
     - PcPlus4D_latched is captured together with pend_tgt.
  6. Otherwise: issue gives pcF<=pcF+4 (wraps modulo 2^ADDR_W); no issue gives a hold.
- jumpD while in WAIT_DS is a protocol violation (decode must stall). The verification assertion fires, and RTL ignores the second jumpD.
- Invariant (assert): when jumpD=1 in IDLE, either last_iss==PcPlus4D or pcF==PcPlus4D.
- stallF held across WAIT_DS: pend_tgt and pcF hold indefinitely with no request. The redirect applies on the first delay-slot issue after stallF drops.
- inst_addr_ok low (SRAM busy): inst_req stays asserted with pcF stable until accepted.
- Reset mid-WAIT_DS: pending discarded; fetch restarts at RESET_PC.
- Latency:
  - Redirect in the delay-slot-issued case: target presented on pcF the cycle after jumpD.
  - Pending case: target presented the cycle after the delay slot is accepted.

Test Plan:
1. Reset then free-run with inst_addr_ok=1 -> first request at 0xBFC00000, followed by 0xBFC00004 and 0xBFC00008 on consecutive cycles.
2. Delay slot 0xBFC00008 already issued, jumpD=1 with pc_jumpD=0x80001000 -> inst_req=0 that cycle; next cycle pcF=0x80001000 and 0xBFC0000C is never requested.
3. jumpD=1 while pcF=PcPlus4D=0xBFC00008 and inst_addr_ok=0 for 3 cycles -> redirect_pending=1 for 3 cycles, pcF stays 0xBFC00008. The cycle after acceptance, pcF=target and redirect_pending=0.
4. Pending jump plus stallF=1 for 5 cycles, then released -> no request during the stall; delay slot issued after release, then the target.
5. ex_redirectM=1 with ex_pcM=0xBFC00380 in the same cycle as jumpD=1 (or while WAIT_DS) -> next pcF=0xBFC00380, redirect_pending=0, jump target never requested.
6. rst asserted while WAIT_DS -> next cycle pcF=0xBFC00000, redirect_pending=0; normal sequential fetch resumes.
